aes_stream_wrapper: RTL and testbench

- Stream-side neighbour of aes_core: packs four 32-bit input words into the 128-bit plain_text, starts the core, waits for done, then unpacks cipher_text into four 32-bit output words.
- Sits between the bus/DMA word stream and aes_core. Key is driven to the core separately and is out of scope.
- Both stream sides use valid/ready handshakes, so the upstream source and downstream sink may stall.

---
 rtl/aes_stream_wrapper.sv | 185 ++++++++++++++++++
 tb/tb_aes_stream_wrapper.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_wrapper.sv
// aes_stream_wrapper: bridges a 32-bit valid/ready word stream and aes_core.
// It packs BLK_W/WORD_W input words into one block, pulses core_start_o, and
// waits for core_done_i. It then shifts the ciphertext block out as words.
// A block whose core never finishes is dropped after TIMEOUT cycles.
//
// Optional build macro: AES_CBC_MODE_EN. When it is defined, the wrapper adds
// iv_i/iv_load_i and a chain register. The core then sees block XOR chain.
// When it is undefined, the core sees the assembled block unchanged (ECB).
//
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   in_data_i/in_valid_i/in_ready_o      plaintext word stream (first word = MSB)
//   out_data_o/out_valid_o/out_ready_i   ciphertext word stream (same order)
//   core_plain_text_o, core_start_o      block and start pulse to aes_core
//   core_cipher_text_i, core_done_i      result and done from aes_core
//   iv_i, iv_load_i           CBC initial vector and load strobe (CBC build only)
//   busy_o                    high unless idle in LOAD with no partial block
//   timeout_err_o             sticky core-timeout flag
module aes_stream_wrapper #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned BLK_W   = 128,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WORD_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [WORD_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
`ifdef AES_CBC_MODE_EN
  input  logic [BLK_W-1:0]  iv_i,
  input  logic              iv_load_i,
`endif
  output logic [BLK_W-1:0]  core_plain_text_o,
  output logic              core_start_o,
  input  logic [BLK_W-1:0]  core_cipher_text_i,
  input  logic              core_done_i,
  output logic              busy_o,
  output logic              timeout_err_o
);

  localparam int unsigned NWORDS = BLK_W / WORD_W;
  localparam int unsigned CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned PART_W = BLK_W - WORD_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_LOAD, ST_START, ST_WAIT, ST_UNLOAD} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PART_W-1:0]  part_q, part_d;    // words collected before the last beat
  logic [BLK_W-1:0]   plain_q, plain_d;
  logic [BLK_W-1:0]   out_q, out_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               start_q, start_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               terr_q, terr_d;
`ifdef AES_CBC_MODE_EN
  logic [BLK_W-1:0]   chain_q, chain_d;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    part_d      = part_q;
    plain_d     = plain_q;
    out_d       = out_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    terr_d      = terr_q;
`ifdef AES_CBC_MODE_EN
    chain_d     = chain_q;
`endif
    case (state_q)
      ST_LOAD: begin
`ifdef AES_CBC_MODE_EN
        if (iv_load_i && (cnt_q == '0)) chain_d = iv_i;
`endif
        if (in_valid_i && in_ready_q) begin
          part_d = PART_W'({part_q, in_data_i});
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = ST_START;
`ifdef AES_CBC_MODE_EN
            plain_d = {part_q, in_data_i} ^ chain_q;
`else
            plain_d = {part_q, in_data_i};
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_START: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // done wins over a timeout that expires in the same cycle
        if (core_done_i) begin
          out_d       = core_cipher_text_i;
          out_valid_d = 1'b1;
          state_d     = ST_UNLOAD;
`ifdef AES_CBC_MODE_EN
          chain_d     = core_cipher_text_i;
`endif
        end else if (tmo_q == TMO_LAST) begin
          terr_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_UNLOAD: begin
        if (out_ready_i) begin
          out_d = out_q << WORD_W;
          if (cnt_q == LAST_CNT) begin
            cnt_d       = '0;
            out_valid_d = 1'b0;
            state_d     = ST_LOAD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    // Flags derive from the next state so they are registered but not late
    start_d    = (state_d == ST_START);
    in_ready_d = (state_d == ST_LOAD);
    busy_d     = !((state_d == ST_LOAD) && (cnt_d == '0));
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      part_q      <= '0;
      plain_q     <= '0;
      out_q       <= '0;
      tmo_q       <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
`ifdef AES_CBC_MODE_EN
      chain_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      part_q      <= part_d;
      plain_q     <= plain_d;
      out_q       <= out_d;
      tmo_q       <= tmo_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
`ifdef AES_CBC_MODE_EN
      chain_q     <= chain_d;
`endif
    end
  end

  assign in_ready_o        = in_ready_q;
  assign out_data_o        = out_q[BLK_W-1 -: WORD_W];
  assign out_valid_o       = out_valid_q;
  assign core_plain_text_o = plain_q;
  assign core_start_o      = start_q;
  assign busy_o            = busy_q;
  assign timeout_err_o     = terr_q;

endmodule

// File: tb/tb_aes_stream_wrapper.sv
// Self-checking bench for aes_stream_wrapper with a behavioural aes_core stand-in.
module tb_aes_stream_wrapper;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLK_W   = 128;
  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned NW      = BLK_W / WORD_W;

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  // core inputs/outputs for the two CBC blocks (plaintext already chained)
  localparam logic [127:0] CBC_X1 = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] CBC_C1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC_X2 = 128'hd86421fb9f1a1eda505ee1375746972c;
  localparam logic [127:0] CBC_C2 = 128'h5086cb9b507219ee95db113a917678b2;

  logic              clk_i;
  logic              rst_ni;
  logic [WORD_W-1:0] in_data_i;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [WORD_W-1:0] out_data_o;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [BLK_W-1:0]  core_plain_text_o;
  logic              core_start_o;
  logic [BLK_W-1:0]  core_cipher_text_i;
  logic              core_done_i;
  logic              busy_o;
  logic              timeout_err_o;
`ifdef AES_CBC_MODE_EN
  logic [BLK_W-1:0]  iv_i;
  logic              iv_load_i;
`endif

  aes_stream_wrapper #(.WORD_W(WORD_W), .BLK_W(BLK_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .in_data_i          (in_data_i),
    .in_valid_i         (in_valid_i),
    .in_ready_o         (in_ready_o),
    .out_data_o         (out_data_o),
    .out_valid_o        (out_valid_o),
    .out_ready_i        (out_ready_i),
`ifdef AES_CBC_MODE_EN
    .iv_i               (iv_i),
    .iv_load_i          (iv_load_i),
`endif
    .core_plain_text_o  (core_plain_text_o),
    .core_start_o       (core_start_o),
    .core_cipher_text_i (core_cipher_text_i),
    .core_done_i        (core_done_i),
    .busy_o             (busy_o),
    .timeout_err_o      (timeout_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int first_ov_cyc = 0;
  int last_beat_cyc = 0;
  int pop_cnt = 0;
  int core_lat = 3;
  int out_mode = 0;   // 0: always ready, 1: random, 2: never ready
  bit ov_seen = 1'b0;
  bit never_mode = 1'b0;
  bit late_mode = 1'b0;
  logic [31:0]  exp_q[$];
  logic [127:0] plain_q[$];

  typedef struct {
    logic [127:0] pt;
    logic [127:0] ct;
    int           gap;
    int           mode;
    int           lat;
  } vec_t;
  vec_t vecs[4];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arbitrary invertible stand-in cipher for blocks without a known AES vector
  function automatic logic [127:0] fake_ct(input logic [127:0] p);
    return {p[63:0], p[127:64]} ^ 128'hc3c3c3c3_3c3c3c3c_a5a5a5a5_5a5a5a5a;
  endfunction

  function automatic logic [127:0] core_lookup(input logic [127:0] p);
    case (p)
      FIPS_PT: return FIPS_CT;
      CBC_X1:  return CBC_C1;
      CBC_X2:  return CBC_C2;
      default: return fake_ct(p);
    endcase
  endfunction

  task automatic push_words(input logic [127:0] ct);
    for (int i = 0; i < NW; i++) exp_q.push_back(ct[BLK_W-1-WORD_W*i -: WORD_W]);
  endtask

  // Sink ready pattern, changed only after the rising edge
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (out_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = 1'($urandom_range(0, 1));
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard pops, stall stability, start counting
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_stall = 1'b0;
      end else begin
        if (core_start_o) begin
          start_cnt++;
          start_cyc = cyc;
        end
        if (prev_stall) begin
          check("stall_valid", 128'(out_valid_o), 128'(1));
          check("stall_data", 128'(out_data_o), 128'(prev_data));
        end
        if (out_valid_o && !ov_seen) begin
          ov_seen      = 1'b1;
          first_ov_cyc = cyc;
        end
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL out_word: unexpected word %h", out_data_o);
          end else begin
            check("out_word", 128'(out_data_o), 128'(exp_q.pop_front()));
            pop_cnt++;
          end
        end
        prev_stall = out_valid_o && !out_ready_i;
        prev_data  = out_data_o;
      end
    end
  end

  // aes_core stand-in: answers each start after core_lat cycles
  initial begin
    logic [127:0] pt_m;
    logic [127:0] ct_m;
    bit           aborted;
    core_done_i        = 1'b0;
    core_cipher_text_i = '0;
    forever begin
      @(negedge clk_i);
      if (rst_ni && core_start_o) begin
        pt_m = core_plain_text_o;
        if (plain_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL core_start: unexpected start with block %h", pt_m);
        end else begin
          check("core_plain_text", pt_m, plain_q.pop_front());
        end
        ct_m = core_lookup(pt_m);
        if (late_mode) begin
          core_done_i        = 1'b1;
          core_cipher_text_i = ~ct_m;
          @(negedge clk_i);
          core_done_i        = 1'b0;
          core_cipher_text_i = '0;
          @(negedge clk_i);
          core_done_i        = 1'b1;
          core_cipher_text_i = ct_m;
          done_cyc           = cyc;
          @(negedge clk_i);
          core_done_i        = 1'b0;
        end else if (!never_mode) begin
          aborted = 1'b0;
          for (int i = 0; i < core_lat; i++) begin
            @(negedge clk_i);
            if (!rst_ni) aborted = 1'b1;
          end
          if (!aborted && rst_ni) begin
            core_done_i        = 1'b1;
            core_cipher_text_i = ct_m;
            done_cyc           = cyc;
            @(negedge clk_i);
            core_done_i        = 1'b0;
          end
        end
      end
    end
  end

  // Drive one block; returns on the falling edge after the last beat
  task automatic send_block(input logic [127:0] pt, input int gap_max);
    int t;
    int g;
    for (int i = 0; i < NW; i++) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      in_valid_i = 1'b0;
      repeat (g) @(negedge clk_i);
      in_data_i  = pt[BLK_W-1-WORD_W*i -: WORD_W];
      in_valid_i = 1'b1;
      t = 0;
      while (!in_ready_o && t < 400) begin
        @(negedge clk_i);
        t++;
      end
      if (t >= 400) begin
        n_checks++;
        n_errors++;
        $display("FAIL in_ready: word %0d never accepted, ready=%b", i, in_ready_o);
      end
      last_beat_cyc = cyc;
      @(negedge clk_i);
    end
    in_valid_i = 1'b0;
    in_data_i  = '0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy_o) && t < 600) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 600) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: drain timeout, %0d words left, busy=%b", name, exp_q.size(), busy_o);
    end
    repeat (3) @(negedge clk_i);
    check({name, "_idle_ready"}, 128'(in_ready_o), 128'(1));
  endtask

  task automatic do_reset(input string name);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check({name, "_in_ready"}, 128'(in_ready_o), 128'(0));
    check({name, "_out_valid"}, 128'(out_valid_o), 128'(0));
    check({name, "_out_data"}, 128'(out_data_o), 128'(0));
    check({name, "_core_start"}, 128'(core_start_o), 128'(0));
    check({name, "_plain"}, core_plain_text_o, 128'(0));
    check({name, "_terr"}, 128'(timeout_err_o), 128'(0));
    check({name, "_busy"}, 128'(busy_o), 128'(0));
    exp_q.delete();
    plain_q.delete();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check({name, "_ready_after"}, 128'(in_ready_o), 128'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1);
  end

  initial begin
    int s0;
    int p0;
    int t;
    int terr_cyc;

    vecs[0].pt = FIPS_PT; vecs[0].ct = FIPS_CT; vecs[0].gap = 0; vecs[0].mode = 0; vecs[0].lat = 3;
    vecs[1].pt = 128'h0;  vecs[1].ct = fake_ct(128'h0); vecs[1].gap = 2; vecs[1].mode = 1; vecs[1].lat = 1;
    vecs[2].pt = {128{1'b1}}; vecs[2].ct = fake_ct({128{1'b1}});
    vecs[2].gap = 1; vecs[2].mode = 0; vecs[2].lat = 7;
    vecs[3].pt = 128'h0123456789abcdeffedcba9876543210;
    vecs[3].ct = fake_ct(128'h0123456789abcdeffedcba9876543210);
    vecs[3].gap = 3; vecs[3].mode = 1; vecs[3].lat = 12;

    rst_ni     = 1'b0;
    in_valid_i = 1'b0;
    in_data_i  = '0;
`ifdef AES_CBC_MODE_EN
    iv_i      = '0;
    iv_load_i = 1'b1;
`endif
    repeat (2) @(negedge clk_i);
    check("reset_in_ready", 128'(in_ready_o), 128'(0));
    check("reset_out_valid", 128'(out_valid_o), 128'(0));
    check("reset_core_start", 128'(core_start_o), 128'(0));
    check("reset_plain", core_plain_text_o, 128'(0));
    check("reset_terr", 128'(timeout_err_o), 128'(0));
    check("reset_busy", 128'(busy_o), 128'(0));
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_reset_ready", 128'(in_ready_o), 128'(1));

    // Table of single blocks with varying gaps, sink patterns and core latency
    for (int v = 0; v < 4; v++) begin
      out_mode = vecs[v].mode;
      core_lat = vecs[v].lat;
      push_words(vecs[v].ct);
      plain_q.push_back(vecs[v].pt);
      s0 = start_cnt;
      ov_seen = 1'b0;
      send_block(vecs[v].pt, vecs[v].gap);
      check("busy_active", 128'(busy_o), 128'(1));
      check("in_ready_blocked", 128'(in_ready_o), 128'(0));
      wait_idle("vec");
      check("start_pulses", 128'(start_cnt - s0), 128'(1));
      check("beat_to_start", 128'(start_cyc - last_beat_cyc), 128'(1));
      check("done_to_valid", 128'(first_ov_cyc - done_cyc), 128'(1));
      check("idle_busy", 128'(busy_o), 128'(0));
    end

    // Two back-to-back copies under random backpressure
    out_mode = 1;
    core_lat = 4;
    s0 = start_cnt;
    p0 = pop_cnt;
    for (int b = 0; b < 2; b++) begin
      push_words(FIPS_CT);
      plain_q.push_back(FIPS_PT);
      send_block(FIPS_PT, 3);
    end
    wait_idle("backpressure");
    check("bp_starts", 128'(start_cnt - s0), 128'(2));
    check("bp_words", 128'(pop_cnt - p0), 128'(2 * NW));
    out_mode = 0;

    // done during START must be ignored; capture on the later WAIT done
    late_mode = 1'b1;
    push_words(FIPS_CT);
    plain_q.push_back(FIPS_PT);
    ov_seen = 1'b0;
    send_block(FIPS_PT, 0);
    wait_idle("late_done");
    check("late_done_to_valid", 128'(first_ov_cyc - done_cyc), 128'(1));
    late_mode = 1'b0;

    // Core never answers
    never_mode = 1'b1;
    plain_q.push_back(FIPS_PT);
    ov_seen = 1'b0;
    send_block(FIPS_PT, 0);
    t = 0;
    while (!timeout_err_o && t < 300) begin
      @(negedge clk_i);
      t++;
    end
    terr_cyc = cyc;
    check("timeout_err", 128'(timeout_err_o), 128'(1));
    check("timeout_cycles", 128'(terr_cyc - start_cyc), 128'(TIMEOUT + 1));
    check("timeout_no_valid", 128'(ov_seen), 128'(0));
    check("timeout_idle", 128'(busy_o), 128'(0));
    never_mode = 1'b0;
    core_lat = 3;
    push_words(FIPS_CT);
    plain_q.push_back(FIPS_PT);
    send_block(FIPS_PT, 1);
    wait_idle("after_timeout");
    check("timeout_sticky", 128'(timeout_err_o), 128'(1));

    // Reset while waiting for the core
    core_lat = 20;
    plain_q.push_back(FIPS_PT);
    send_block(FIPS_PT, 0);
    repeat (5) @(negedge clk_i);
    check("wait_busy", 128'(busy_o), 128'(1));
    do_reset("rst_wait");
    core_lat = 3;
    push_words(FIPS_CT);
    plain_q.push_back(FIPS_PT);
    send_block(FIPS_PT, 0);
    wait_idle("after_rst_wait");

    // Reset while the second output word is stalled
    core_lat = 2;
    out_mode = 2;
    push_words(FIPS_CT);
    plain_q.push_back(FIPS_PT);
    p0 = pop_cnt;
    send_block(FIPS_PT, 0);
    t = 0;
    while (!out_valid_o && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    check("unload_valid", 128'(out_valid_o), 128'(1));
    out_mode = 0;
    @(negedge clk_i);
    out_mode = 2;
    @(negedge clk_i);
    check("unload_one_word", 128'(pop_cnt - p0), 128'(1));
    do_reset("rst_unload");
    out_mode = 0;
    push_words(FIPS_CT);
    plain_q.push_back(FIPS_PT);
    send_block(FIPS_PT, 2);
    wait_idle("after_rst_unload");

`ifdef AES_CBC_MODE_EN
    // SP 800-38A CBC-AES128 first two blocks
    iv_i      = 128'h000102030405060708090a0b0c0d0e0f;
    iv_load_i = 1'b1;
    core_lat  = 5;
    push_words(CBC_C1);
    plain_q.push_back(CBC_X1);
    send_block(128'h6bc1bee22e409f96e93d7e117393172a, 0);
    iv_load_i = 1'b0;
    push_words(CBC_C2);
    plain_q.push_back(CBC_X2);
    send_block(128'hae2d8a571e03ac9c9eb76fac45af8e51, 1);
    wait_idle("cbc");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
